req_grant_ctrl: RTL

Sequential request/grant controller wrapped around the 8-way combinational fixed-priority arbiter (bit 0 highest priority). It captures request pulses from 8 clients into sticky pending bits and drives the pending vector to the arbiter. It then registers the arbiter's one-hot grant, holds it for a programmable burst length, and signals completion. It sits directly upstream of the arbiter, which feeds it, and downstream of the client request sources.

---
 rtl/req_grant_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/req_grant_ctrl.sv
// req_grant_ctrl
//   Request/grant sequencer placed in front of an external 8-way
//   combinational fixed-priority arbiter (bit 0 highest priority).
//   Request pulses are captured into sticky pending bits. The pending
//   vector is presented to the arbiter, and the returned one-hot grant is
//   registered and held for a programmable burst length. A done pulse
//   follows the last grant cycle.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   req_in   in   [7:0] request pulses, one bit per client
//   len      in   [CNT_W-1:0] grant hold length, sampled at grant issue (0 -> 1)
//   arb_req  out  [7:0] pending vector to the arbiter (register output)
//   arb_gnt  in   [7:0] arbiter grant, combinational from arb_req
//   gnt      out  [7:0] registered one-hot grant to clients
//   busy     out  high whenever the FSM is not in IDLE
//   done     out  one-cycle pulse after the last grant cycle
//   gnt_err  out  sticky grant-check error
//
// Build option
//   GNT_CHECK_EN : when defined, each arbitration in IDLE checks that
//                  arb_gnt is one-hot and a subset of pending. Any
//                  violation sets gnt_err until reset. When undefined,
//                  gnt_err is tied to 0.
//
// state | meaning
// IDLE  | waiting for a pending request; arbitrates when pending != 0
// GRANT | grant held; cnt counts down the remaining grant cycles
// GAP   | done pulse cycle; returns to IDLE

module req_grant_ctrl #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       req_in,
  input  logic [CNT_W-1:0] len,
  output logic [7:0]       arb_req,
  input  logic [7:0]       arb_gnt,
  output logic [7:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             gnt_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [7:0]       pending_q;
  logic [7:0]       gnt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;

  logic             arb_now;
  logic [7:0]       clr_d;
  logic [7:0]       pending_d;

  assign arb_now   = (state_q == IDLE) && (pending_q != 8'h00);
  assign clr_d     = arb_now ? arb_gnt : 8'h00;
  // Set wins over clear, so a client re-requesting on its grant edge is re-queued.
  assign pending_d = (pending_q & ~clr_d) | req_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= 8'h00;
      gnt_q     <= 8'h00;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (arb_now) begin
            gnt_q   <= arb_gnt;
            cnt_q   <= (len == '0) ? '0 : (len - CNT_ONE);
            busy_q  <= 1'b1;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else begin
            gnt_q   <= 8'h00;
            done_q  <= 1'b1;
            state_q <= GAP;
          end
        end
        GAP: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          gnt_q   <= 8'h00;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign arb_req = pending_q;
  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef GNT_CHECK_EN
  logic gnt_err_q;
  logic gnt_onehot;
  logic gnt_bad;

  assign gnt_onehot = (arb_gnt != 8'h00) && ((arb_gnt & (arb_gnt - 8'd1)) == 8'h00);
  assign gnt_bad    = !gnt_onehot || ((arb_gnt & ~pending_q) != 8'h00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_err_q <= 1'b0;
    end else if (arb_now && gnt_bad) begin
      gnt_err_q <= 1'b1;
    end
  end

  assign gnt_err = gnt_err_q;
`else
  assign gnt_err = 1'b0;
`endif

endmodule
